// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the multiply/divide unit
//               (operation codes, FSM states, helper function).
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Larger of two integers, used to size the latency counter.
  function automatic int md_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Execute-stage request/response bundle of the multiply/divide
//               unit. The master issues operations, the slave owns HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  import muldiv_pkg::*;

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, hi, lo);

endinterface
`default_nettype wire

// File: rtl/muldiv_calc.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_calc
// Description : Combinational arithmetic for the multiply/divide unit.
//               Produces the HI/LO value that will be committed at the end
//               of a multi-cycle operation.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_calc
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] pending_hi_o,
  output logic [WIDTH-1:0] pending_lo_o
);

  localparam int               W2  = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [W2-1:0]    w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [W2-1:0]    w_sprod, w_uprod, w_acc, w_res;
  logic             w_a_neg, w_b_neg, w_signed_div;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_dn, w_dd, w_uq, w_ur, w_q, w_r;

  // Products are taken on 2*WIDTH extended operands so the truncated result
  // is the exact two's-complement product modulo 2^(2*WIDTH).
  assign w_a_sx  = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign w_b_sx  = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign w_a_zx  = {{WIDTH{1'b0}}, a_i};
  assign w_b_zx  = {{WIDTH{1'b0}}, b_i};
  assign w_sprod = w_a_sx * w_b_sx;
  assign w_uprod = w_a_zx * w_b_zx;
  assign w_acc   = {hi_i, lo_i};

  // One unsigned divider serves both DIV and DIVU; DIV works on magnitudes
  // and restores signs afterwards. The most negative dividend has a
  // magnitude of 2^(WIDTH-1), which still fits unsigned, so the
  // -2^(WIDTH-1) / -1 case falls out naturally as LO=-2^(WIDTH-1), HI=0.
  assign w_signed_div = (op_i == OP_DIV);
  assign w_a_neg      = w_signed_div & a_i[WIDTH-1];
  assign w_b_neg      = w_signed_div & b_i[WIDTH-1];
  assign w_abs_a      = w_a_neg ? (~a_i + ONE) : a_i;
  assign w_abs_b      = w_b_neg ? (~b_i + ONE) : b_i;
  assign w_dn         = w_abs_a;
  assign w_dd         = w_abs_b;
  assign w_uq         = (w_dd == '0) ? '0 : (w_dn / w_dd);
  assign w_ur         = (w_dd == '0) ? '0 : (w_dn % w_dd);
  assign w_q          = (w_a_neg ^ w_b_neg) ? (~w_uq + ONE) : w_uq;
  assign w_r          = w_a_neg ? (~w_ur + ONE) : w_ur;

  // Select the result; divide by zero re-commits the current HI/LO.
  always_comb begin
    w_res = w_acc;
    case (op_i)
      OP_MULT:  w_res = w_sprod;
      OP_MULTU: w_res = w_uprod;
      OP_MADD:  w_res = w_acc + w_sprod;
      OP_MSUB:  w_res = w_acc - w_sprod;
      OP_DIV,
      OP_DIVU:  w_res = (b_i == '0) ? w_acc : {w_r, w_q};
      default:  w_res = w_acc;
    endcase
  end

  assign pending_hi_o = w_res[W2-1:WIDTH];
  assign pending_lo_o = w_res[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//               The result is computed at issue, held in pending registers
//               and committed when the latency counter expires, so busy
//               timing is independent of operand values.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);

  localparam int               CNT_W    = $clog2(md_max(MUL_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic [WIDTH-1:0] pend_hi_d, pend_lo_d;

  muldiv_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op_i         (md.op),
    .a_i          (md.a),
    .b_i          (md.b),
    .hi_i         (hi_q),
    .lo_i         (lo_q),
    .pending_hi_o (pend_hi_d),
    .pending_lo_o (pend_lo_d)
  );

  // Issue/count/commit FSM; flush beats both a new start and a due commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.start && !md.flush) begin
            case (md.op)
              OP_MTHI: hi_q <= md.a;
              OP_MTLO: lo_q <= md.a;
              OP_DIV, OP_DIVU: begin
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                cnt_q     <= DIV_LOAD;
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
              default: begin
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                cnt_q     <= MUL_LOAD;
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
            endcase
          end
        end
        RUN: begin
          if (md.flush) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_ONE) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit: a 32-bit 5/10-cycle
//               instance with directed vectors and a 16-bit 1/1-cycle
//               instance checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_if #(.WIDTH(16)) bus2 ();

  muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk), .reset (reset), .md (bus)
  );
  muldiv_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut2 (
    .clk (clk), .reset (reset), .md (bus2)
  );

  typedef struct {
    int          id;
    logic [63:0] hilo;
    int          cycles;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit unit: every busy fall is a completion.
  logic        prev1 = 1'b0, moved1 = 1'b0;
  int          run1 = 0;
  logic [63:0] held1 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy && !prev1) begin
      held1 = {bus.hi, bus.lo}; moved1 = 1'b0; run1 = 0;
    end
    if (bus.busy) begin
      run1++;
      if ({bus.hi, bus.lo} !== held1) moved1 = 1'b1;
    end
    if (prev1 && !bus.busy) begin
      if (sb1.size() == 0) begin
        chk("dut32_unexpected_completion", 64'd1, 64'd0);
      end else begin
        e = sb1.pop_front();
        chk($sformatf("dut32_op%0d_hilo", e.id), {bus.hi, bus.lo}, e.hilo);
        chk($sformatf("dut32_op%0d_busy_cycles", e.id), 64'(run1), 64'(e.cycles));
        chk($sformatf("dut32_op%0d_hilo_stable_while_busy", e.id), 64'(moved1), 64'd0);
      end
    end
    prev1 = bus.busy;
  end

  // Monitor for the 16-bit unit.
  logic prev2 = 1'b0;
  int   run2 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus2.busy && !prev2) run2 = 0;
    if (bus2.busy) run2++;
    if (prev2 && !bus2.busy) begin
      if (sb2.size() == 0) begin
        chk("dut16_unexpected_completion", 64'd1, 64'd0);
      end else begin
        e = sb2.pop_front();
        chk($sformatf("dut16_op%0d_hilo", e.id), 64'({bus2.hi, bus2.lo}), e.hilo);
        chk($sformatf("dut16_op%0d_busy_cycles", e.id), 64'(run2), 64'(e.cycles));
      end
    end
    prev2 = bus2.busy;
  end

  task automatic expect1(input int id, input logic [63:0] hl, input int cyc);
    exp_t e;
    e.id = id; e.hilo = hl; e.cycles = cyc;
    sb1.push_back(e);
  endtask

  task automatic expect2(input int id, input logic [31:0] hl, input int cyc);
    exp_t e;
    e.id = id; e.hilo = 64'(hl); e.cycles = cyc;
    sb2.push_back(e);
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    bus.op = op; bus.a = a; bus.b = b; bus.flush = fl; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic issue2(input md_op_e op, input logic [15:0] a, input logic [15:0] b);
    bus2.op = op; bus2.a = a; bus2.b = b; bus2.flush = 1'b0; bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk); #1;
      if (sb1.size() == 0 && sb2.size() == 0 && !bus.busy && !bus2.busy) done = 1'b1;
    end
    if (!done) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  // Independent reference for the 16-bit instance using 64-bit integers.
  function automatic logic [31:0] ref16(input md_op_e op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [31:0] hl);
    longint sa, sbv, ua, ub, acc, p, q, r;
    logic [31:0] res;
    sa = longint'($signed(a)); sbv = longint'($signed(b));
    ua = longint'(a); ub = longint'(b); acc = longint'(hl);
    res = hl;
    case (op)
      OP_MULT:  begin p = sa * sbv;       res = p[31:0]; end
      OP_MULTU: begin p = ua * ub;        res = p[31:0]; end
      OP_MADD:  begin p = acc + sa * sbv; res = p[31:0]; end
      OP_MSUB:  begin p = acc - sa * sbv; res = p[31:0]; end
      OP_DIV:   if (b != 0) begin q = sa / sbv; r = sa % sbv; res = {r[15:0], q[15:0]}; end
      OP_DIVU:  if (b != 0) begin q = ua / ub;  r = ua % ub;  res = {r[15:0], q[15:0]}; end
      OP_MTHI:  res = {a, hl[15:0]};
      OP_MTLO:  res = {hl[31:16], a};
      default:  res = hl;
    endcase
    return res;
  endfunction

  md_op_e      vop[10];
  logic [15:0] va[10];
  logic [15:0] vb[10];
  logic [31:0] m_hl2;

  initial begin
    bus.start = 0; bus.flush = 0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
    bus2.start = 0; bus2.flush = 0; bus2.op = OP_MULT; bus2.a = '0; bus2.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);

    // MULT / MULTU / DIV / DIVU-by-zero, issued back-to-back
    expect1(1, 64'hFFFFFFFF_FFFFFFFA, 5);  issue(OP_MULT,  32'hFFFFFFFE, 32'd3, 1'b0); wait_idle();
    expect1(2, 64'h00000002_FFFFFFFA, 5);  issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0); wait_idle();
    expect1(3, 64'hFFFFFFFF_FFFFFFFD, 10); issue(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
    expect1(4, 64'hFFFFFFFF_FFFFFFFD, 10); issue(OP_DIVU,  32'd7,        32'd0, 1'b0); wait_idle();

    // MTHI visible after one edge with busy low
    issue(OP_MTHI, 32'h12345678, 32'd0, 1'b0);
    chk("mthi_hi", 64'(bus.hi), 64'h12345678);
    chk("mthi_lo_kept", 64'(bus.lo), 64'hFFFFFFFD);
    chk("mthi_busy", 64'(bus.busy), 64'd0);

    // MADD carrying from LO into HI, then MSUB
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
    chk("mtlo_lo", 64'(bus.lo), 64'hFFFFFFFF);
    expect1(5, 64'h00000001_00000000, 5); issue(OP_MADD, 32'd1, 32'd1, 1'b0); wait_idle();
    expect1(6, 64'h00000000_FFFFFFFA, 5); issue(OP_MSUB, 32'd2, 32'd3, 1'b0); wait_idle();

    // Stray start during RUN must not disturb HI/LO
    expect1(7, 64'h00000000_0000000C, 5);
    issue(OP_MULT, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    bus.op = OP_MTHI; bus.a = 32'hDEADBEEF; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle();

    // Flush in the third busy cycle
    expect1(8, 64'h00000000_0000000C, 3);
    issue(OP_MULT, 32'd5, 32'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    wait_idle();

    // Flush coinciding with the commit edge
    expect1(9, 64'h00000000_0000000C, 5);
    issue(OP_MULT, 32'd5, 32'd5, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    wait_idle();

    // Flush coinciding with start: nothing accepted
    issue(OP_MULT, 32'd5, 32'd5, 1'b1);
    chk("flush_start_busy", 64'(bus.busy), 64'd0);
    issue(OP_MTHI, 32'hAAAA5555, 32'd0, 1'b1);
    chk("flush_start_busy_later", 64'(bus.busy), 64'd0);
    chk("flush_start_mthi_hi", 64'(bus.hi), 64'd0);
    chk("flush_start_lo", 64'(bus.lo), 64'hC);

    // Most-negative / -1 division
    expect1(10, 64'h00000000_80000000, 10); issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle();

    // Reset in the fourth busy cycle of a DIV
    expect1(11, 64'h0, 4);
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("reset_mid_busy", 64'(bus.busy), 64'd0);
    chk("reset_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    wait_idle();

    // 16-bit, single-cycle instance against the reference model
    vop = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIV, OP_DIVU, OP_MTHI, OP_DIV, OP_MADD, OP_MTLO, OP_MSUB};
    va  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0007, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h7FFF, 16'h0001, 16'h8000};
    vb  = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0010, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF};
    m_hl2 = 32'h0;
    for (int i = 0; i < 10; i++) begin
      m_hl2 = ref16(vop[i], va[i], vb[i], m_hl2);
      if (vop[i] != OP_MTHI && vop[i] != OP_MTLO) expect2(100 + i, m_hl2, 1);
      issue2(vop[i], va[i], vb[i]);
      wait_idle();
    end
    chk("dut16_final_hilo", 64'({bus2.hi, bus2.lo}), 64'(m_hl2));

    chk("scoreboard32_drained", 64'(sb1.size()), 64'd0);
    chk("scoreboard16_drained", 64'(sb2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
